// File: rtl/fei4_rx_word_formatter_pkg.sv
// Shared definitions for the FE-I4 receiver readout path.
// Holds the record-type codes, the field offsets of the 32-bit readout word,
// the output-register state type and helpers that assemble readout words.
package fei4_rx_pkg;

   localparam int REC_W    = 24;
   localparam int WORD_W   = 32;
   localparam int TYPE_LSB = 24;
   localparam int ID_LSB   = 28;

   localparam logic [3:0] TYPE_DATA   = 4'h0;
   localparam logic [3:0] TYPE_DH     = 4'h1;
   localparam logic [3:0] TYPE_STATUS = 4'hF;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } oreg_state_t;

   function automatic logic [WORD_W-1:0] make_data_word(
      input logic [3:0]       id,
      input logic             is_dh,
      input logic [REC_W-1:0] rec
   );
      logic [WORD_W-1:0] w;
      w                  = '0;
      w[ID_LSB +: 4]     = id;
      w[TYPE_LSB +: 4]   = is_dh ? TYPE_DH : TYPE_DATA;
      w[REC_W-1:0]       = rec;
      return w;
   endfunction

   function automatic logic [WORD_W-1:0] make_status_word(
      input logic [3:0] id,
      input logic [7:0] lost_cnt
   );
      logic [WORD_W-1:0] w;
      w                  = '0;
      w[ID_LSB +: 4]     = id;
      w[TYPE_LSB +: 4]   = TYPE_STATUS;
      w[7:0]             = lost_cnt;
      return w;
   endfunction

endpackage

// File: rtl/fei4_rx_word_formatter_if.sv
// FIFO-style handshake bundle: first-word-fall-through data with an empty
// flag and a pop strobe.
//   DATA  : word at the head of the FIFO, valid while EMPTY=0
//   EMPTY : no word available
//   READ  : pop strobe from the consumer
// master = the side that holds the data, slave = the side that pops it.
interface fei4_rx_word_formatter_if #(
   parameter int DW = 32
) ();
   logic [DW-1:0] DATA;
   logic          EMPTY;
   logic          READ;

   modport master (output DATA, output EMPTY, input READ);
   modport slave  (input DATA, input EMPTY, output READ);
endinterface

// File: rtl/fei4_rx_word_formatter_rst_sync.sv
// Reset synchronizer cell: asserts asynchronously, releases after two
// clock edges so that downstream flops leave reset cleanly.
//   clk        : destination clock
//   rst_n_in   : raw active-low reset
//   rst_n_out  : synchronized active-low reset
module fei4_rx_word_formatter_rst_sync (
   input  logic clk,
   input  logic rst_n_in,
   output logic rst_n_out
);
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], 1'b1};
      end
   end

   assign rst_n_out = sync_q[1];
endmodule

// File: rtl/fei4_rx_word_formatter.sv
// FE-I4 receiver output stage. Pops 24-bit records from the receiver FIFO,
// tags them with channel ID and record type, and presents them as 32-bit
// readout words through a one-entry output register. A status word carrying
// the receiver lost-word counter is inserted ahead of the next data word
// whenever that counter changes.
//   BUS_CLK      : clock
//   BUS_RST_N    : asynchronous active-low reset (release synchronized)
//   ENABLE       : allows popping new records; the output still drains when low
//   LOST_ERR_CNT : receiver lost-word counter
//   RX           : receiver record FIFO (24-bit, consumed here)
//   FIFO         : readout word output (32-bit, popped by the arbiter)
//   FRAME_CNT    : data headers loaded, saturating
//   WORD_CNT     : data words popped downstream, wrapping
//
// state    | meaning
// ST_EMPTY | output register holds no valid word (FIFO.EMPTY=1)
// ST_FULL  | output register holds a word waiting for FIFO.READ
module fei4_rx_word_formatter
   import fei4_rx_pkg::*;
#(
   parameter logic [3:0] IDENTIFIER = 4'b0000,
   parameter logic [7:0] DH_BYTE    = 8'hE9
) (
   input  logic                      BUS_CLK,
   input  logic                      BUS_RST_N,
   input  logic                      ENABLE,
   input  logic [7:0]                LOST_ERR_CNT,
   fei4_rx_word_formatter_if.slave   RX,
   fei4_rx_word_formatter_if.master  FIFO,
   output logic [15:0]               FRAME_CNT,
   output logic [31:0]               WORD_CNT
);

   logic              rst_n_sync;
   oreg_state_t       state_q, state_d;
   logic [WORD_W-1:0] oreg_q;
   logic              oreg_is_data_q;
   logic [7:0]        last_lost_q;
   logic [15:0]       frame_cnt_q;
   logic [31:0]       word_cnt_q;

   logic              slot_free;
   logic              status_pend;
   logic              rec_is_dh;
   logic              load_status;
   logic              load_data;

   fei4_rx_word_formatter_rst_sync u_rst_sync (
      .clk       (BUS_CLK),
      .rst_n_in  (BUS_RST_N),
      .rst_n_out (rst_n_sync)
   );

   assign rec_is_dh = (RX.DATA[23:16] == DH_BYTE);

   always_ff @(posedge BUS_CLK or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // A pending status word always wins the free slot so that the loss report
   // precedes any data popped after the counter moved.
   always_comb begin
      state_d     = state_q;
      load_status = 1'b0;
      load_data   = 1'b0;
      slot_free   = (state_q == ST_EMPTY) || FIFO.READ;
      status_pend = (LOST_ERR_CNT != last_lost_q);
      if (rst_n_sync && slot_free) begin
         if (status_pend) begin
            load_status = 1'b1;
            state_d     = ST_FULL;
         end else if (ENABLE && !RX.EMPTY) begin
            load_data = 1'b1;
            state_d   = ST_FULL;
         end else begin
            state_d = ST_EMPTY;
         end
      end
   end

   always_ff @(posedge BUS_CLK or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         oreg_q         <= '0;
         oreg_is_data_q <= 1'b0;
         last_lost_q    <= 8'h00;
         frame_cnt_q    <= 16'h0000;
      end else if (load_status) begin
         // Sampling the counter at load time collapses several changes into
         // one status word carrying the latest value.
         oreg_q         <= make_status_word(IDENTIFIER, LOST_ERR_CNT);
         oreg_is_data_q <= 1'b0;
         last_lost_q    <= LOST_ERR_CNT;
      end else if (load_data) begin
         oreg_q         <= make_data_word(IDENTIFIER, rec_is_dh, RX.DATA);
         oreg_is_data_q <= 1'b1;
         if (rec_is_dh && (frame_cnt_q != 16'hFFFF)) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge BUS_CLK or negedge rst_n_sync) begin
      if (!rst_n_sync) begin
         word_cnt_q <= 32'h0;
      end else if ((state_q == ST_FULL) && FIFO.READ && oreg_is_data_q) begin
         word_cnt_q <= word_cnt_q + 32'd1;
      end
   end

   assign RX.READ    = load_data;
   assign FIFO.DATA  = oreg_q;
   assign FIFO.EMPTY = (state_q == ST_EMPTY);
   assign FRAME_CNT  = frame_cnt_q;
   assign WORD_CNT   = word_cnt_q;

endmodule

// File: tb/tb_fei4_rx_word_formatter.sv
module tb_fei4_rx_word_formatter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic [7:0]  lost;
   logic [15:0] frame_cnt;
   logic [31:0] word_cnt;

   always #5 clk = ~clk;

   fei4_rx_word_formatter_if #(.DW(24)) rx_if ();
   fei4_rx_word_formatter_if #(.DW(32)) fifo_if ();

   fei4_rx_word_formatter dut (
      .BUS_CLK      (clk),
      .BUS_RST_N    (rst_n),
      .ENABLE       (enable),
      .LOST_ERR_CNT (lost),
      .RX           (rx_if.slave),
      .FIFO         (fifo_if.master),
      .FRAME_CNT    (frame_cnt),
      .WORD_CNT     (word_cnt)
   );

   int          checks = 0;
   int          errors = 0;
   logic [23:0] rxq[$];
   logic [31:0] expq[$];
   int          tb_words = 0;
   int          tb_frames = 0;
   logic [7:0]  last_rep = 8'h00;
   int          n_status = 0;
   logic [31:0] last_status = 32'h0;
   logic        rd_last = 1'b0;
   logic [31:0] mon_w;
   logic [31:0] mon_e;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Receiver FIFO model + expected readout word built from the record rules.
   task automatic push_rec(input logic [23:0] r);
      rxq.push_back(r);
      expq.push_back({4'h0, (r[23:16] == 8'hE9) ? 4'h1 : 4'h0, r});
   endtask

   task automatic step();
      rx_if.DATA  = (rxq.size() != 0) ? rxq[0] : 24'h0;
      rx_if.EMPTY = (rxq.size() == 0);
      @(negedge clk);
      rd_last = rx_if.READ;
      if (rd_last && rx_if.EMPTY) check("rx_read_when_empty", 32'(rd_last), 32'h0);
      @(posedge clk);
      #1;
      if (rd_last && rxq.size() != 0) void'(rxq.pop_front());
   endtask

   task automatic drain();
      int n;
      enable        = 1'b1;
      fifo_if.READ  = 1'b1;
      n = 0;
      while (!(rxq.size() == 0 && expq.size() == 0 && fifo_if.EMPTY && last_rep == lost) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) check("drain_timeout", 32'(n), 32'd0);
   endtask

   // Monitor: every popped word is either the next expected data word or a
   // status word reporting a new lost-counter value.
   always @(negedge clk) begin
      if (rst_n && fifo_if.READ && !fifo_if.EMPTY) begin
         mon_w = fifo_if.DATA;
         if (mon_w[27:24] == 4'hF) begin
            checks++;
            if (mon_w[31:8] !== 24'h0F0000 || mon_w[7:0] == last_rep) begin
               errors++;
               $display("FAIL status_word actual=%08h previous_report=%02h", mon_w, last_rep);
            end
            last_rep    = mon_w[7:0];
            last_status = mon_w;
            n_status++;
         end else if (expq.size() == 0) begin
            check("unexpected_data", mon_w, 32'hxxxxxxxx);
         end else begin
            mon_e = expq.pop_front();
            check("data_word", mon_w, mon_e);
            tb_words++;
            if (mon_e[27:24] == 4'h1) tb_frames++;
         end
      end
      if (rst_n && rx_if.READ && !fifo_if.EMPTY && !fifo_if.READ)
         check("overwrite_guard", 32'(rx_if.READ), 32'h0);
   end

   initial begin
      int pulses;
      int ns0;
      logic [31:0] held;
      logic [23:0] r;

      rst_n        = 1'b0;
      enable       = 1'b1;
      lost         = 8'h00;
      fifo_if.READ = 1'b0;
      rx_if.DATA   = 24'h123456;
      rx_if.EMPTY  = 1'b0;
      #12;
      check("rst_fifo_empty", 32'(fifo_if.EMPTY), 32'h1);
      check("rst_fifo_data", fifo_if.DATA, 32'h0);
      check("rst_rx_read", 32'(rx_if.READ), 32'h0);
      check("rst_frame_cnt", 32'(frame_cnt), 32'h0);
      check("rst_word_cnt", word_cnt, 32'h0);
      rx_if.EMPTY = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (3) step();

      // Back-to-back stream, one word per cycle.
      push_rec(24'hE90102);
      push_rec(24'h123456);
      push_rec(24'hABCDEF);
      fifo_if.READ = 1'b1;
      repeat (4) step();
      check("t1_word_cnt", word_cnt, 32'd3);
      check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
      check("t1_empty", 32'(fifo_if.EMPTY), 32'h1);

      // Downstream stall: only one pop, held word stable.
      fifo_if.READ = 1'b0;
      for (int i = 0; i < 4; i++) push_rec(24'h300000 + 24'(i));
      step();
      pulses = int'(rd_last);
      held   = fifo_if.DATA;
      for (int i = 0; i < 9; i++) begin
         step();
         pulses += int'(rd_last);
         check("t2_stall_stable", fifo_if.DATA, held);
      end
      check("t2_one_pop", 32'(pulses), 32'd1);
      drain();

      // Lost counter change while streaming.
      for (int i = 0; i < 6; i++) push_rec(24'h400000 + 24'(i));
      fifo_if.READ = 1'b1;
      step();
      step();
      lost = 8'd5;
      step();
      check("t3_no_rx_read", 32'(rd_last), 32'h0);
      check("t3_status_word", fifo_if.DATA, 32'h0F000005);
      check("t3_not_empty", 32'(fifo_if.EMPTY), 32'h0);
      drain();

      // Several changes during a stall collapse into one status word.
      push_rec(24'h500001);
      push_rec(24'h500002);
      push_rec(24'hE95003);
      fifo_if.READ = 1'b0;
      step();
      ns0  = n_status;
      lost = 8'd1; step();
      lost = 8'd2; step();
      lost = 8'd3; step();
      drain();
      check("t4_status_count", 32'(n_status - ns0), 32'd1);
      check("t4_status_value", last_status, 32'h0F000003);

      // ENABLE low: no pops, output register drains.
      for (int i = 0; i < 4; i++) push_rec(24'h600000 + 24'(i));
      fifo_if.READ = 1'b0;
      step();
      enable       = 1'b0;
      fifo_if.READ = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("t5_no_rx_read", 32'(rd_last), 32'h0);
      end
      check("t5_empty", 32'(fifo_if.EMPTY), 32'h1);
      check("t5_left_in_rx", 32'(rxq.size()), 32'd3);
      drain();

      // Reset while a word is held.
      push_rec(24'h700001);
      push_rec(24'hE9ABCD);
      fifo_if.READ = 1'b0;
      step();
      step();
      #2;
      rst_n = 1'b0;
      lost  = 8'h00;
      #1;
      check("t6_rst_empty", 32'(fifo_if.EMPTY), 32'h1);
      check("t6_rst_frame", 32'(frame_cnt), 32'h0);
      check("t6_rst_word", word_cnt, 32'h0);
      check("t6_rst_rx_read", 32'(rx_if.READ), 32'h0);
      void'(expq.pop_front());
      tb_words  = 0;
      tb_frames = 0;
      last_rep  = 8'h00;
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) step();
      check("t6_first_word", fifo_if.DATA, 32'h01E9ABCD);
      check("t6_first_valid", 32'(fifo_if.EMPTY), 32'h0);
      drain();
      check("t6_frame_cnt", 32'(frame_cnt), 32'd1);
      check("t6_word_cnt", word_cnt, 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 2) == 0 && rxq.size() < 6) begin
            r = 24'($urandom);
            if ($urandom_range(0, 3) == 0) r[23:16] = 8'hE9;
            push_rec(r);
         end
         fifo_if.READ = ($urandom_range(0, 3) != 0);
         enable       = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 29) == 0)
            lost = (lost > 8'd250) ? 8'hFF : lost + 8'($urandom_range(1, 4));
         step();
      end
      drain();
      check("rand_status_final", 32'(last_rep), 32'(lost));
      check("rand_word_cnt", word_cnt, 32'(tb_words));
      check("rand_frame_cnt", 32'(frame_cnt), 32'(tb_frames));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
